// File: rtl/uart_tx_queue_if.sv
// Producer/controller side signal bundle for the UART transmit byte queue.
// The queue is the slave; the producer plus transmit controller form the master side.
interface uart_tx_queue_if #(
  parameter int AW = 4
);
  logic          wrEn;
  logic [7:0]    wrData;
  logic          ovfClr;
  logic          txReady;
  logic          txSend;
  logic [7:0]    txData;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output wrEn, wrData, ovfClr, txReady,
    input  txSend, txData, full, empty, count, overflow
  );

  modport slave (
    input  wrEn, wrData, ovfClr, txReady,
    output txSend, txData, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO in front of the UART transmit controller: accepts bursty pushes and
// feeds the controller one byte per send/ready handshake.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_queue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic [7:0]    txData;
  logic          txSend;
  logic          overflow;
  state_t        state;
  state_t        nextState;
  logic          popEn;
  logic          pushEn;
  logic          dropPush;

  // Pop handshake: one pop per controller character, waiting for busy then idle
  always_comb begin
    nextState = state;
    popEn     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && bus.txReady) begin
          popEn     = 1'b1;
          nextState = SEND;
        end
      end
      SEND:      nextState = WAIT_BUSY;
      WAIT_BUSY: if (!bus.txReady) nextState = WAIT_DONE;
      WAIT_DONE: if (bus.txReady) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // A full queue still accepts a push when a pop frees a slot in the same cycle
  assign pushEn   = bus.wrEn && (count != FULL_COUNT || popEn);
  assign dropPush = bus.wrEn && !pushEn;

  // txSend is registered from the next state so it has no input-to-output path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      txSend <= 1'b0;
    end else begin
      state  <= nextState;
      txSend <= (nextState == SEND);
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn) mem[wrPtr] <= bus.wrData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      txData   <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn) begin
        rdPtr  <= rdPtr + 1'b1;
        txData <= mem[rdPtr];
      end
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push outranks a clear arriving in the same cycle
      if (dropPush)        overflow <= 1'b1;
      else if (bus.ovfClr) overflow <= 1'b0;
    end
  end

  assign bus.txSend   = txSend;
  assign bus.txData   = txData;
  assign bus.count    = count;
  assign bus.full     = (count == FULL_COUNT);
  assign bus.empty    = (count == '0);
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: vector table for fill/overflow, plus hand
// sequences with a simple transmit-controller model for drain, wrap and reset.
module tb_uart_tx_queue;

  typedef struct {
    logic       wrEn;
    logic [7:0] wrData;
    logic       ovfClr;
    logic       txReady;
    logic       expSend;
    logic [7:0] expData;
    logic [4:0] expCount;
    logic       expFull;
    logic       expEmpty;
    logic       expOvf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  logic [7:0] expQ[$];
  vec_t vecs[$];

  uart_tx_queue_if #(.AW(4)) bus ();

  uart_tx_queue #(.DEPTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, then sample 1 ns after the following rising edge
  task automatic applyStimulus(input logic wrEn, input logic [7:0] wrData,
                               input logic ovfClr, input logic txReady);
    bus.wrEn    = wrEn;
    bus.wrData  = wrData;
    bus.ovfClr  = ovfClr;
    bus.txReady = txReady;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVec(input string tag, input vec_t v);
    checkOutput({tag, ".txSend"},   32'(bus.txSend),   32'(v.expSend));
    checkOutput({tag, ".txData"},   32'(bus.txData),   32'(v.expData));
    checkOutput({tag, ".count"},    32'(bus.count),    32'(v.expCount));
    checkOutput({tag, ".full"},     32'(bus.full),     32'(v.expFull));
    checkOutput({tag, ".empty"},    32'(bus.empty),    32'(v.expEmpty));
    checkOutput({tag, ".overflow"}, 32'(bus.overflow), 32'(v.expOvf));
  endtask

  // Controller model drops ready for busyLen cycles after each send; optional pushes
  task automatic runTraffic(input string tag, input int nPush, input int pushGap,
                            input int busyLen, input int expectPulses, input int budget);
    int pushed = 0;
    int pulses = 0;
    int extra = 0;
    int cyc = 0;
    int busy = 0;
    int maxCount = 0;
    logic [7:0] nextByte = 8'h80;
    logic [7:0] expByte;
    while (pulses < expectPulses && cyc < budget) begin
      if (int'(bus.count) > maxCount) maxCount = int'(bus.count);
      if (bus.txSend) begin
        pulses++;
        if (expQ.size() != 0) expByte = expQ.pop_front();
        else expByte = 8'hxx;
        checkOutput($sformatf("%s.byte%0d", tag, pulses), 32'(bus.txData), 32'(expByte));
        busy = busyLen;
      end
      bus.txReady = (busy == 0);
      if (busy > 0) busy--;
      bus.ovfClr = 1'b0;
      bus.wrEn   = 1'b0;
      if (pushed < nPush && (cyc % pushGap) == 0) begin
        bus.wrEn   = 1'b1;
        bus.wrData = nextByte;
        expQ.push_back(nextByte);
        nextByte++;
        pushed++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, ".pulses"}, 32'(pulses), 32'(expectPulses));
    bus.wrEn = 1'b0;
    for (int i = 0; i < busyLen + 6; i++) begin
      if (bus.txSend) extra++;
      bus.txReady = (busy == 0);
      if (busy > 0) busy--;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, ".extraPulses"}, 32'(extra), 32'd0);
    checkOutput({tag, ".maxCountOk"}, 32'(maxCount <= 16), 32'd1);
    checkOutput({tag, ".emptyAfter"}, 32'(bus.empty), 32'd1);
    checkOutput({tag, ".countAfter"}, 32'(bus.count), 32'd0);
    checkOutput({tag, ".leftover"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int quiet;
    bus.wrEn    = 1'b0;
    bus.wrData  = 8'h00;
    bus.ovfClr  = 1'b0;
    bus.txReady = 1'b1;

    // Single byte, then sixteen-byte fill, drop, clear and set-wins-over-clear
    vecs.push_back('{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h41, 5'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 5'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 5'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 5'd0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0, 8'h41, 5'(i + 1), (i == 15), 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h51, 1'b0, 1'b0, 1'b0, 8'h41, 5'd16, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 5'd16, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h52, 1'b1, 1'b0, 1'b0, 8'h41, 5'd16, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 5'd16, 1'b1, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    checkVec("reset", '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wrEn, vecs[i].wrData, vecs[i].ovfClr, vecs[i].txReady);
      checkVec($sformatf("v%0d", i), vecs[i]);
    end

    // Drain the full queue through the controller model
    for (int i = 0; i < 16; i++) expQ.push_back(8'(8'h41 + i));
    runTraffic("drain", 0, 1, 10, 16, 1000);

    // Push into a full queue in the same cycle as an IDLE pop
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      expQ.push_back(8'(8'h70 + i));
    end
    checkOutput("pp.fullBefore", 32'(bus.full), 32'd1);
    applyStimulus(1'b1, 8'h60, 1'b0, 1'b1);
    expQ.push_back(8'h60);
    checkOutput("pp.count",    32'(bus.count),    32'd16);
    checkOutput("pp.overflow", 32'(bus.overflow), 32'd0);
    checkOutput("pp.txSend",   32'(bus.txSend),   32'd1);
    runTraffic("pp", 0, 1, 10, 17, 1000);

    // Interleaved pushes and drains across the pointer wrap
    runTraffic("wrap", 20, 2, 3, 20, 2000);
    checkOutput("wrap.overflow", 32'(bus.overflow), 32'd0);

    // Async reset in WAIT_BUSY with bytes still queued
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    checkOutput("rst.countQueued", 32'(bus.count), 32'd5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("rst.send",  32'(bus.txSend), 32'd1);
    checkOutput("rst.data",  32'(bus.txData), 32'hA0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("rst.countBefore", 32'(bus.count), 32'd4);
    rst = 1'b1;
    #1;
    checkOutput("rst.asyncCount",  32'(bus.count),  32'd0);
    checkOutput("rst.asyncEmpty",  32'(bus.empty),  32'd1);
    checkOutput("rst.asyncSend",   32'(bus.txSend), 32'd0);
    checkOutput("rst.asyncData",   32'(bus.txData), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      if (bus.txSend) quiet++;
    end
    checkOutput("rst.noSendAfter", 32'(quiet), 32'd0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    checkOutput("rst.pushSendEarly", 32'(bus.txSend), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("rst.newSend", 32'(bus.txSend), 32'd1);
    checkOutput("rst.newData", 32'(bus.txData), 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
